// File: rtl/ahb_slave_frontend_if.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_slave_frontend_if
//  Description : Bus bundle between the AHB-Lite master side / APB bridge FSM
//                and the AHB slave front end.
//                AHB side   : HADDR, HWDATA, HTRANS, HWRITE, HSIZE, HREADYin,
//                             HREADY, HRESP, HRDATA
//                Bridge side: HREADYout, PRDATA, valid, HADDR_1..3,
//                             HWDATA_1..3, HWRITEreg, TEMP_SEL
//  Revision    : 1.0  initial release
// ============================================================================
interface ahb_slave_frontend_if;
    logic [31:0] HADDR;
    logic [31:0] HWDATA;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic        HREADYin;
    logic        HREADYout;
    logic [31:0] PRDATA;

    logic        valid;
    logic [31:0] HADDR_1;
    logic [31:0] HADDR_2;
    logic [31:0] HADDR_3;
    logic [31:0] HWDATA_1;
    logic [31:0] HWDATA_2;
    logic [31:0] HWDATA_3;
    logic        HWRITEreg;
    logic [2:0]  TEMP_SEL;
    logic        HREADY;
    logic        HRESP;
    logic [31:0] HRDATA;

    modport slave (
        input  HADDR, HWDATA, HTRANS, HWRITE, HSIZE, HREADYin, HREADYout, PRDATA,
        output valid, HADDR_1, HADDR_2, HADDR_3, HWDATA_1, HWDATA_2, HWDATA_3,
               HWRITEreg, TEMP_SEL, HREADY, HRESP, HRDATA
    );

    modport master (
        output HADDR, HWDATA, HTRANS, HWRITE, HSIZE, HREADYin, HREADYout, PRDATA,
        input  valid, HADDR_1, HADDR_2, HADDR_3, HWDATA_1, HWDATA_2, HWDATA_3,
               HWRITEreg, TEMP_SEL, HREADY, HRESP, HRDATA
    );
endinterface
`default_nettype wire

// File: rtl/ahb_slave_frontend.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_slave_frontend
//  Description : AHB-Lite slave front end of the AHB-to-APB bridge. Qualifies
//                transfers, decodes the one-hot APB slave select, keeps a
//                three-deep address/write-data pipeline and produces the
//                two-cycle AHB ERROR response for unmapped or misaligned
//                transfers.
//  Ports       : HCLK    - AHB clock
//                HRESETn - asynchronous active-low reset
//                bus     - ahb_slave_frontend_if.slave (AHB + bridge signals)
//  Revision    : 1.0  initial release
// ============================================================================
module ahb_slave_frontend #(
    parameter logic [31:0] SLV0_BASE   = 32'h8000_0000,
    parameter logic [31:0] SLV1_BASE   = 32'h8400_0000,
    parameter logic [31:0] SLV2_BASE   = 32'h8800_0000,
    parameter logic [31:0] REGION_SIZE = 32'h0400_0000
) (
    input  wire logic             HCLK,
    input  wire logic             HRESETn,
    ahb_slave_frontend_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_OKAY = 2'd0,
        ST_ERR1 = 2'd1,
        ST_ERR2 = 2'd2
    } state_t;

    state_t      state_q, state_d;

    logic [31:0] haddr1_q, haddr2_q, haddr3_q;
    logic [31:0] hwdata1_q, hwdata2_q, hwdata3_q;
    logic        hwrite_q;
    logic [2:0]  sel_q;

    logic        active;
    logic [2:0]  sel_dec;
    logic        hit;
    logic        aligned;
    logic        bad_xfer;
    logic        valid;
    logic        hready;
    logic        hresp;

    // Offset-from-base compare handles any base, aligned or not, without
    // overflow at the top of the region. Priority chain: lowest index wins.
    always_comb begin
        sel_dec = 3'b000;
        if ((bus.HADDR - SLV0_BASE) < REGION_SIZE) begin
            sel_dec = 3'b001;
        end else if ((bus.HADDR - SLV1_BASE) < REGION_SIZE) begin
            sel_dec = 3'b010;
        end else if ((bus.HADDR - SLV2_BASE) < REGION_SIZE) begin
            sel_dec = 3'b100;
        end
    end

    assign active  = (bus.HTRANS == 2'b10) || (bus.HTRANS == 2'b11);
    assign hit     = |sel_dec;
    assign aligned = (bus.HSIZE == 3'd0)
                  || ((bus.HSIZE == 3'd1) && !bus.HADDR[0])
                  || ((bus.HSIZE == 3'd2) && (bus.HADDR[1:0] == 2'b00));

    assign bad_xfer = bus.HREADYin && active && !(hit && aligned);

    // Gated by HRESETn so the bridge sees no request while reset is held.
    assign valid = HRESETn && bus.HREADYin && active && hit && aligned
                && (state_q != ST_ERR1);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= ST_OKAY;
        end else begin
            state_q <= state_d;
        end
    end

    // ERR1 stalls the master (HREADY=0) while flagging ERROR; ERR2 completes
    // the response. A bad transfer accepted during ERR2 restarts the pair.
    always_comb begin
        state_d = state_q;
        hready  = bus.HREADYout;
        hresp   = 1'b0;
        case (state_q)
            ST_OKAY: begin
                if (bad_xfer) begin
                    state_d = ST_ERR1;
                end
            end
            ST_ERR1: begin
                hready  = 1'b0;
                hresp   = 1'b1;
                state_d = ST_ERR2;
            end
            ST_ERR2: begin
                hready  = 1'b1;
                hresp   = 1'b1;
                state_d = bad_xfer ? ST_ERR1 : ST_OKAY;
            end
            default: begin
                state_d = ST_OKAY;
            end
        endcase
    end

    // Address/data pipeline advances on every accepted bus cycle, whether or
    // not the transfer is for this slave; only select/direction are qualified.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            haddr1_q  <= 32'h0;
            haddr2_q  <= 32'h0;
            haddr3_q  <= 32'h0;
            hwdata1_q <= 32'h0;
            hwdata2_q <= 32'h0;
            hwdata3_q <= 32'h0;
            hwrite_q  <= 1'b0;
            sel_q     <= 3'b000;
        end else begin
            if (bus.HREADYin) begin
                haddr1_q  <= bus.HADDR;
                haddr2_q  <= haddr1_q;
                haddr3_q  <= haddr2_q;
                hwdata1_q <= bus.HWDATA;
                hwdata2_q <= hwdata1_q;
                hwdata3_q <= hwdata2_q;
            end
            if (valid) begin
                hwrite_q <= bus.HWRITE;
                sel_q    <= sel_dec;
            end
        end
    end

    assign bus.valid     = valid;
    assign bus.HADDR_1   = haddr1_q;
    assign bus.HADDR_2   = haddr2_q;
    assign bus.HADDR_3   = haddr3_q;
    assign bus.HWDATA_1  = hwdata1_q;
    assign bus.HWDATA_2  = hwdata2_q;
    assign bus.HWDATA_3  = hwdata3_q;
    assign bus.HWRITEreg = hwrite_q;
    assign bus.TEMP_SEL  = sel_q;
    assign bus.HREADY    = hready;
    assign bus.HRESP     = hresp;
    assign bus.HRDATA    = bus.PRDATA;

endmodule
`default_nettype wire
